// File: rtl/spi_reg_pkg.sv
// Shared state encoding, header layout and default bytes for the SPI register bridge.
package spi_reg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD_ISSUE,
        RD_STREAM,
        WR_STREAM,
        WR_ISSUE
    } state_t;

    localparam int         RW_BIT          = 7;
    localparam int         ADDR_MSB        = 6;
    localparam logic [7:0] ID_BYTE_DEFAULT = 8'hA5;
    localparam logic [7:0] TIMEOUT_BYTE    = 8'hFF;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_reg <= RST_VAL;
            q        <= RST_VAL;
        end else begin
            meta_reg <= d;
            q        <= meta_reg;
        end
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Bridges SPI frames (header byte + data stream) onto a simple request/ack register bus.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter logic [7:0] ID_BYTE     = ID_BYTE_DEFAULT,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss,
    input  logic       spi_done,
    input  logic [7:0] spi_rx_data,
    output logic [7:0] spi_tx_data,
    output logic       reg_req,
    output logic       reg_we,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic       reg_ack,
    input  logic [7:0] reg_rdata,
    output logic       frame_active,
    output logic       err_overrun,
    output logic       err_timeout
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    state_t        state_reg;
    logic          ss_s;
    logic [CW-1:0] cnt_reg;
    logic          timed_out;

    sync_2ff #(.RST_VAL(1'b1)) u_ss_sync (
        .clk (clk),
        .rst (rst),
        .d   (ss),
        .q   (ss_s)
    );

    // cnt_reg holds the number of cycles reg_req has already been high.
    assign timed_out = (cnt_reg == CW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            reg_req      <= 1'b0;
            reg_we       <= 1'b0;
            reg_addr     <= '0;
            reg_wdata    <= '0;
            spi_tx_data  <= ID_BYTE;
            frame_active <= 1'b0;
            err_overrun  <= 1'b0;
            err_timeout  <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!ss_s) begin
                        state_reg    <= HDR;
                        frame_active <= 1'b1;
                    end
                end
                HDR: begin
                    if (ss_s) begin
                        state_reg    <= IDLE;
                        frame_active <= 1'b0;
                    end else if (spi_done) begin
                        reg_addr <= spi_rx_data[ADDR_MSB:0];
                        if (spi_rx_data[RW_BIT]) begin
                            state_reg <= WR_STREAM;
                        end else begin
                            state_reg <= RD_ISSUE;
                            reg_req   <= 1'b1;
                            reg_we    <= 1'b0;
                            cnt_reg   <= '0;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (reg_ack || timed_out) begin
                        reg_req     <= 1'b0;
                        err_timeout <= !reg_ack;
                        spi_tx_data <= reg_ack ? reg_rdata : TIMEOUT_BYTE;
                        if (ss_s) begin
                            state_reg    <= IDLE;
                            frame_active <= 1'b0;
                            spi_tx_data  <= ID_BYTE;
                        end else begin
                            state_reg <= RD_STREAM;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                RD_STREAM: begin
                    if (ss_s) begin
                        state_reg    <= IDLE;
                        frame_active <= 1'b0;
                        spi_tx_data  <= ID_BYTE;
                    end else if (spi_done) begin
                        // Prefetch the next address so it is ready before the next byte end.
                        reg_addr  <= reg_addr + 7'd1;
                        reg_req   <= 1'b1;
                        reg_we    <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= RD_ISSUE;
                    end
                end
                WR_STREAM: begin
                    if (ss_s) begin
                        state_reg    <= IDLE;
                        frame_active <= 1'b0;
                    end else if (spi_done) begin
                        reg_wdata <= spi_rx_data;
                        reg_req   <= 1'b1;
                        reg_we    <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= WR_ISSUE;
                    end
                end
                WR_ISSUE: begin
                    err_overrun <= spi_done && !ss_s;
                    if (reg_ack || timed_out) begin
                        reg_req     <= 1'b0;
                        err_timeout <= !reg_ack;
                        reg_addr    <= reg_addr + 7'd1;
                        if (ss_s) begin
                            state_reg    <= IDLE;
                            frame_active <= 1'b0;
                        end else begin
                            state_reg <= WR_STREAM;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    reg_req      <= 1'b0;
                    frame_active <= 1'b0;
                    spi_tx_data  <= ID_BYTE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench: SPI host and register-file models drive spi_reg_ctrl and check frames.
module tb_spi_reg_ctrl;

    localparam logic [7:0] ID  = 8'hA5;
    localparam int         GAP = 24;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss;
    logic       spi_done;
    logic [7:0] spi_rx_data;
    logic [7:0] spi_tx_data;
    logic       reg_req;
    logic       reg_we;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_ack;
    logic [7:0] reg_rdata;
    logic       frame_active;
    logic       err_overrun;
    logic       err_timeout;

    spi_reg_ctrl #(.ID_BYTE(8'hA5), .ACK_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .ss           (ss),
        .spi_done     (spi_done),
        .spi_rx_data  (spi_rx_data),
        .spi_tx_data  (spi_tx_data),
        .reg_req      (reg_req),
        .reg_we       (reg_we),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_ack      (reg_ack),
        .reg_rdata    (reg_rdata),
        .frame_active (frame_active),
        .err_overrun  (err_overrun),
        .err_timeout  (err_timeout)
    );

    initial forever #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          ack_lat  = 3;
    logic [7:0]  mem [128];
    logic [15:0] log_q[$];
    int          len_q[$];
    logic [7:0]  miso_q[$];
    int          age;
    bit          acked;
    int          ovr_cnt;
    int          to_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register-file model: acks each request ack_lat cycles after it rises (never if ack_lat <= 0).
    initial begin
        age = 0;
        acked = 1'b0;
        reg_ack = 1'b0;
        reg_rdata = 8'h00;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        forever begin
            @(negedge clk);
            reg_ack = 1'b0;
            if (reg_req) begin
                if (age == 0) log_q.push_back({reg_we, reg_addr, reg_wdata});
                age++;
                if (!acked && ack_lat > 0 && age == ack_lat) begin
                    acked = 1'b1;
                    reg_ack = 1'b1;
                    if (reg_we) mem[reg_addr] = reg_wdata;
                    else reg_rdata = mem[reg_addr];
                end
            end else begin
                if (age > 0) len_q.push_back(age);
                age = 0;
                acked = 1'b0;
            end
        end
    end

    initial begin
        ovr_cnt = 0;
        to_cnt = 0;
        forever begin
            @(negedge clk);
            if (err_overrun) ovr_cnt++;
            if (err_timeout) to_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // SPI host model: byte 0 is what the slave holds at ss fall, byte k+1 what it holds at byte k end.
    task automatic frame_begin();
        @(negedge clk);
        miso_q.delete();
        miso_q.push_back(spi_tx_data);
        ss = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        spi_rx_data = b;
        spi_done = 1'b1;
        miso_q.push_back(spi_tx_data);
        @(negedge clk);
        spi_done = 1'b0;
    endtask

    task automatic frame_end();
        repeat (GAP) @(negedge clk);
        ss = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic do_read(input logic [6:0] a, input int n, input int lat);
        int lb, eo, et;
        logic [6:0] ea;
        ack_lat = lat;
        lb = log_q.size();
        eo = ovr_cnt;
        et = to_cnt;
        frame_begin();
        send_byte({1'b0, a}, GAP);
        for (int i = 1; i < n; i++) send_byte(8'($urandom), GAP);
        frame_end();
        $display("read frame addr=%02h bytes=%0d lat=%0d", a, n, lat);
        check("rd_miso_len", miso_q.size(), n + 1);
        for (int k = 0; k <= n && k < miso_q.size(); k++) begin
            ea = a + 7'(k) - 7'd2;
            check("rd_miso", miso_q[k], (k < 2) ? ID : mem[ea]);
        end
        check("rd_count", log_q.size() - lb, n);
        for (int i = 0; i < n && lb + i < log_q.size(); i++)
            check("rd_req", log_q[lb+i][15:8], {1'b0, a + 7'(i)});
        check("rd_ovr", ovr_cnt - eo, 0);
        check("rd_to", to_cnt - et, 0);
        check("rd_idle_fa", frame_active, 1'b0);
        check("rd_idle_tx", spi_tx_data, ID);
    endtask

    task automatic do_write(input logic [6:0] a, input int n, input int lat);
        int lb, eo;
        logic [7:0] d [8];
        ack_lat = lat;
        lb = log_q.size();
        eo = ovr_cnt;
        for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
        frame_begin();
        send_byte({1'b1, a}, GAP);
        for (int i = 0; i < n; i++) send_byte(d[i], GAP);
        frame_end();
        $display("write frame addr=%02h data_bytes=%0d lat=%0d", a, n, lat);
        for (int k = 0; k < miso_q.size(); k++) check("wr_miso", miso_q[k], ID);
        check("wr_count", log_q.size() - lb, n);
        for (int i = 0; i < n && lb + i < log_q.size(); i++)
            check("wr_req", log_q[lb+i], {1'b1, a + 7'(i), d[i]});
        check("wr_ovr", ovr_cnt - eo, 0);
        check("wr_idle_fa", frame_active, 1'b0);
    endtask

    task automatic do_write_list(input logic [6:0] a, input logic [23:0] dl);
        int lb;
        ack_lat = 3;
        lb = log_q.size();
        frame_begin();
        send_byte({1'b1, a}, GAP);
        for (int i = 0; i < 3; i++) send_byte(dl[23-8*i -: 8], GAP);
        frame_end();
        $display("write frame addr=%02h data=%06h", a, dl);
        check("wrap_count", log_q.size() - lb, 3);
        for (int i = 0; i < 3 && lb + i < log_q.size(); i++)
            check("wrap_req", log_q[lb+i], {1'b1, a + 7'(i), dl[23-8*i -: 8]});
    endtask

    initial begin
        int lb, eo, et, ll;
        rst = 1'b0;
        ss = 1'b1;
        spi_done = 1'b0;
        spi_rx_data = 8'h00;
        repeat (4) @(negedge clk);
        check("rst_req", reg_req, 1'b0);
        check("rst_we", reg_we, 1'b0);
        check("rst_addr", reg_addr, 7'h00);
        check("rst_wdata", reg_wdata, 8'h00);
        check("rst_tx", spi_tx_data, ID);
        check("rst_fa", frame_active, 1'b0);
        check("rst_ovr", err_overrun, 1'b0);
        check("rst_to", err_timeout, 1'b0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Read from 0x10 with a 3-cycle register file.
        do_read(7'h10, 3, 3);

        // Write crossing the top of the address space.
        do_write_list(7'h7E, 24'h112233);

        // Overrun: a second byte lands while the first write is still outstanding.
        ack_lat = 10;
        lb = log_q.size();
        eo = ovr_cnt;
        frame_begin();
        send_byte(8'hA0, GAP);
        send_byte(8'h5A, GAP);
        send_byte(8'h77, 3);
        frame_end();
        $display("overrun frame addr=20 data=5a,77");
        check("ovr_pulse", ovr_cnt - eo, 1);
        check("ovr_count", log_q.size() - lb, 1);
        if (log_q.size() > lb) check("ovr_req", log_q[lb], {1'b1, 7'h20, 8'h5A});

        // Timeout: no ack at all on a read.
        ack_lat = 0;
        lb = log_q.size();
        ll = len_q.size();
        et = to_cnt;
        frame_begin();
        send_byte(8'h05, GAP);
        send_byte(8'h00, GAP);
        frame_end();
        $display("timeout frame addr=05");
        check("to_miso_len", miso_q.size(), 3);
        if (miso_q.size() > 2) check("to_miso2", miso_q[2], 8'hFF);
        check("to_pulses", to_cnt - et, 2);
        check("to_count", log_q.size() - lb, 2);
        if (len_q.size() > ll) check("to_req_len", len_q[ll], 16);
        check("to_idle_tx", spi_tx_data, ID);

        // Abort in the middle of the header.
        lb = log_q.size();
        frame_begin();
        repeat (16) @(negedge clk);
        check("abort_hdr_fa_on", frame_active, 1'b1);
        ss = 1'b1;
        repeat (3) @(negedge clk);
        $display("abort frame after 4 header bits");
        check("abort_hdr_fa_off", frame_active, 1'b0);
        check("abort_hdr_req", log_q.size() - lb, 0);
        repeat (4) @(negedge clk);

        // Abort while a write is outstanding: the write must still complete.
        ack_lat = 8;
        lb = log_q.size();
        frame_begin();
        send_byte(8'hC0, GAP);
        send_byte(8'h3C, GAP);
        @(negedge clk);
        ss = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_wr_req_held", reg_req, 1'b1);
        check("abort_wr_fa_held", frame_active, 1'b1);
        repeat (12) @(negedge clk);
        $display("abort frame during write addr=40 data=3c");
        check("abort_wr_fa_off", frame_active, 1'b0);
        check("abort_wr_count", log_q.size() - lb, 1);
        if (log_q.size() > lb) check("abort_wr_req", log_q[lb], {1'b1, 7'h40, 8'h3C});

        // Reset while a read request is outstanding.
        ack_lat = 0;
        frame_begin();
        send_byte(8'h30, GAP);
        repeat (4) @(negedge clk);
        check("rstmid_req_on", reg_req, 1'b1);
        rst = 1'b0;
        ss = 1'b1;
        @(negedge clk);
        $display("reset during read addr=30");
        check("rstmid_req_off", reg_req, 1'b0);
        check("rstmid_tx", spi_tx_data, ID);
        check("rstmid_fa", frame_active, 1'b0);
        rst = 1'b1;
        repeat (6) @(negedge clk);

        // Randomized frames against the reference model.
        for (int t = 0; t < 14; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(7'($urandom_range(0, 127)), $urandom_range(1, 4), $urandom_range(1, 8));
            else
                do_read(7'($urandom_range(0, 127)), $urandom_range(1, 4), $urandom_range(1, 8));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
